// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit_if
//  Brief    : Fetch-side bundle: instruction-memory address/data, redirect
//             request, and the {pc, instr} valid/ready channel toward decode.
//  Revision : 1.0 - initial release
// ============================================================================
interface fetch_unit_if #(
  parameter int PC_WIDTH = 16
);
  logic [PC_WIDTH-1:0] imem_pc;
  logic [31:0]         imem_instr;
  logic                redirect_valid;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic                instr_valid;
  logic [31:0]         instr;
  logic [PC_WIDTH-1:0] instr_pc;
  logic                instr_ready;

  // Fetch unit side
  modport master (
    output imem_pc,
    input  imem_instr,
    input  redirect_valid,
    input  redirect_pc,
    output instr_valid,
    output instr,
    output instr_pc,
    input  instr_ready
  );

  // Memory / decode / branch-resolution side
  modport slave (
    input  imem_pc,
    output imem_instr,
    output redirect_valid,
    output redirect_pc,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    output instr_ready
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Brief    : Owns the PC, fetches from a combinational instruction memory and
//             buffers {pc, instr} pairs in a small circular FIFO for decode.
//             Redirects flush the buffer and restart fetch at the new PC.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int                  PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = 16'h0000,
  parameter int                  DEPTH    = 2
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  fetch_unit_if.master  bus
);

  localparam int                  c_PTR_W    = $clog2(DEPTH);
  localparam int                  c_CNT_W    = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0]  c_FULL_CNT = c_CNT_W'(DEPTH);
  localparam logic [c_PTR_W-1:0]  c_PTR_ONE  = c_PTR_W'(1);
  localparam logic [PC_WIDTH-1:0] c_PC_STEP  = PC_WIDTH'(4);
  localparam logic [PC_WIDTH-1:0] c_PC_ALIGN = ~PC_WIDTH'(3);

  logic [PC_WIDTH-1:0] r_pc;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_CNT_W-1:0]  r_count;
  logic [31:0]         r_mem_instr [DEPTH];
  logic [PC_WIDTH-1:0] r_mem_pc    [DEPTH];

  logic                w_full;
  logic                w_empty;
  logic                w_deq;
  logic                w_fetch_ok;
  logic                w_push;
  logic [PC_WIDTH-1:0] w_redirect_pc;

  // Handshake terms; a redirect suppresses the push of the stale word
  always_comb begin
    w_full        = (r_count == c_FULL_CNT);
    w_empty       = (r_count == '0);
    w_deq         = !w_empty && bus.instr_ready;
    w_fetch_ok    = !w_full || w_deq;
    w_push        = w_fetch_ok && !bus.redirect_valid;
    w_redirect_pc = bus.redirect_pc & c_PC_ALIGN;
  end

  // PC, pointers and occupancy; redirect flushes and has top priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (bus.redirect_valid) begin
      r_pc     <= w_redirect_pc;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_pc     <= r_pc + c_PC_STEP;
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_deq);
    end
  end

  // Buffer storage; contents are only meaningful under the count, so no reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_instr[r_wr_ptr] <= bus.imem_instr;
      r_mem_pc[r_wr_ptr]    <= r_pc;
    end
  end

  // Head entry presented combinationally; zeros when the buffer is empty
  always_comb begin
    bus.imem_pc     = r_pc;
    bus.instr_valid = !w_empty;
    bus.instr       = w_empty ? 32'h0 : r_mem_instr[r_rd_ptr];
    bus.instr_pc    = w_empty ? '0 : r_mem_pc[r_rd_ptr];
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Brief    : Directed self-checking bench for fetch_unit: streaming,
//             backpressure, redirects, async reset and PC wrap-around.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic clk;
  logic rst_n;
  logic rst_n_b;

  int n_cmp;
  int n_err;

  fetch_unit_if #(.PC_WIDTH(16)) ifa ();
  fetch_unit_if #(.PC_WIDTH(16)) ifb ();

  // Main instance, reset PC at zero
  fetch_unit #(.PC_WIDTH(16), .RESET_PC(16'h0000), .DEPTH(2)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.master)
  );

  // Second instance to exercise PC wrap-around
  fetch_unit #(.PC_WIDTH(16), .RESET_PC(16'hFFF8), .DEPTH(2)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n_b),
    .bus   (ifb.master)
  );

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: mem_word = 32'hFFC4A303;
      16'h0004: mem_word = 32'h0064A423;
      16'h0008: mem_word = 32'h0062E233;
      16'h000C: mem_word = 32'hFE420AE3;
      default:  mem_word = 32'h00000013;
    endcase
  endfunction

  assign ifa.imem_instr = mem_word(ifa.imem_pc);
  assign ifb.imem_instr = mem_word(ifb.imem_pc);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle just after the last one
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_head(input string tag, input logic v, input logic [15:0] pc,
                            input logic [31:0] ins);
    check_value({tag, ".valid"}, 64'(ifa.instr_valid), 64'(v));
    check_value({tag, ".pc"},    64'(ifa.instr_pc),    64'(pc));
    check_value({tag, ".instr"}, 64'(ifa.instr),       64'(ins));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n   = 1'b0;
    rst_n_b = 1'b0;
    ifa.instr_ready    = 1'b1;
    ifa.redirect_valid = 1'b0;
    ifa.redirect_pc    = 16'h0;
    ifb.instr_ready    = 1'b1;
    ifb.redirect_valid = 1'b0;
    ifb.redirect_pc    = 16'h0;

    // ---- Reset state ----
    step(1);
    check_head("rst", 1'b0, 16'h0000, 32'h0);
    check_value("rst.imem_pc", 64'(ifa.imem_pc), 64'h0000);

    // ---- Streaming with decode always ready ----
    rst_n = 1'b1;
    step(1);
    check_head("s0", 1'b1, 16'h0000, 32'hFFC4A303);
    step(1);
    check_head("s1", 1'b1, 16'h0004, 32'h0064A423);
    step(1);
    check_head("s2", 1'b1, 16'h0008, 32'h0062E233);
    step(1);
    check_head("s3", 1'b1, 16'h000C, 32'hFE420AE3);

    // ---- Backpressure from reset ----
    rst_n = 1'b0;
    ifa.instr_ready = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(2);
    check_value("bp.imem_pc_full", 64'(ifa.imem_pc), 64'h0008);
    check_head("bp.head", 1'b1, 16'h0000, 32'hFFC4A303);
    step(1);
    check_value("bp.imem_pc_stall", 64'(ifa.imem_pc), 64'h0008);
    check_head("bp.hold", 1'b1, 16'h0000, 32'hFFC4A303);
    ifa.instr_ready = 1'b1;
    step(1);
    check_head("bp.d1", 1'b1, 16'h0004, 32'h0064A423);
    step(1);
    check_head("bp.d2", 1'b1, 16'h0008, 32'h0062E233);

    // ---- Redirect while full (buffer holds 0x08, 0x0C) ----
    ifa.instr_ready = 1'b0;
    check_value("rf.imem_pc_pre", 64'(ifa.imem_pc), 64'h0010);
    ifa.redirect_valid = 1'b1;
    ifa.redirect_pc    = 16'h000E;
    step(1);
    ifa.redirect_valid = 1'b0;
    check_head("rf.flush", 1'b0, 16'h0000, 32'h0);
    check_value("rf.imem_pc", 64'(ifa.imem_pc), 64'h000C);
    step(1);
    check_head("rf.first", 1'b1, 16'h000C, 32'hFE420AE3);

    // ---- Redirect with simultaneous dequeue ----
    step(1);
    check_head("rd.full", 1'b1, 16'h000C, 32'hFE420AE3);
    ifa.instr_ready    = 1'b1;
    ifa.redirect_valid = 1'b1;
    ifa.redirect_pc    = 16'h0004;
    step(1);
    ifa.redirect_valid = 1'b0;
    check_head("rd.flush", 1'b0, 16'h0000, 32'h0);
    check_value("rd.imem_pc", 64'(ifa.imem_pc), 64'h0004);
    step(1);
    check_head("rd.n0", 1'b1, 16'h0004, 32'h0064A423);
    step(1);
    check_head("rd.n1", 1'b1, 16'h0008, 32'h0062E233);

    // ---- Async reset between edges ----
    #2;
    rst_n = 1'b0;
    #1;
    check_value("ar.valid",   64'(ifa.instr_valid), 64'h0);
    check_value("ar.imem_pc", 64'(ifa.imem_pc),     64'h0000);
    check_value("ar.instr",   64'(ifa.instr),       64'h0);
    step(1);
    rst_n = 1'b1;

    // ---- PC wrap-around on the second instance ----
    check_value("wr.rst_pc", 64'(ifb.imem_pc), 64'hFFF8);
    rst_n_b = 1'b1;
    step(1);
    check_value("wr.p0", 64'(ifb.instr_pc), 64'hFFF8);
    step(1);
    check_value("wr.p1", 64'(ifb.instr_pc), 64'hFFFC);
    step(1);
    check_value("wr.p2", 64'(ifb.instr_pc), 64'h0000);
    check_value("wr.i2", 64'(ifb.instr),    64'hFFC4A303);
    step(1);
    check_value("wr.p3", 64'(ifb.instr_pc), 64'h0004);
    check_value("wr.v3", 64'(ifb.instr_valid), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Fetch-side initiator for the combinational instruction memory: owns the PC, drives the fetch address, captures the returned 32-bit word, and hands {pc, instr} pairs to decode over a valid/ready handshake.
- A small FIFO decouples the fetch loop from decode stalls.
- Branch/jump redirects flush the FIFO and restart fetch at the new PC.
- Sits between the instruction memory and the decode stage of the single-cycle core.

Parameters:
PC_WIDTH, 16, width of PC and fetch address
RESET_PC, 16'h0000, PC loaded on reset
DEPTH, 2, instruction buffer entries (power of two, >= 2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
imem_pc  output  PC_WIDTH  fetch address to instruction memory (equals the PC register)
imem_instr  input  32  instruction word returned combinationally for imem_pc
redirect_valid  input  1  pulse: abandon sequential fetch
redirect_pc  input  PC_WIDTH  redirect target
instr_valid  output  1  buffer head holds a valid instruction
instr  output  32  head instruction word
instr_pc  output  PC_WIDTH  address of head instruction
instr_ready  input  1  decode accepts head this cycle

Behaviour:
- Reset (async assert, sync release):
  - pc = RESET_PC; FIFO empty; instr_valid = 0; instr = 0; instr_pc = 0.
  - Reset mid-operation discards all buffered entries immediately.
- Handshake terms:
  - deq = instr_valid && instr_ready.
  - fetch_ok = !full || deq.
- Normal cycle, redirect_valid = 0:
  - If fetch_ok: push {pc, imem_instr} at the edge and set pc <= pc + 4.
  - If full && !deq: no push and pc holds; imem_pc stays stable for the whole stall.
  - If deq: pop the head. Push and pop may occur on the same edge, and the count is unchanged.
- Redirect cycle, redirect_valid = 1 (highest priority):
  - FIFO flushed to empty at the edge.
  - pc <= {redirect_pc[PC_WIDTH-1:2], 2'b00}; low bits are forced to zero.
  - No push that cycle; the word at the old pc is discarded.
  - A simultaneous deq still counts as delivered to decode. Nothing else survives the flush.
  - instr_valid = 0 in the cycle after the redirect. The first post-redirect instruction appears one cycle later.
- Latency:
  - Address to instr_valid is 1 cycle.
  - After reset release, instr_valid rises after the first clk edge, with instr_pc = RESET_PC.
  - Sustained throughput is 1 instruction/cycle while instr_ready = 1.
- Outputs:
  - instr and instr_pc reflect the head entry combinationally from FIFO storage.
  - Both read 0 when empty.
  - Head contents are stable while instr_valid && !instr_ready.
- PC arithmetic: pc + 4 wraps modulo 2^PC_WIDTH, e.g. 16'hFFFC -> 16'h0000. No overflow flag.
- FIFO implementation:
  - Circular buffer with read/write pointers of log2(DEPTH) bits plus a count of log2(DEPTH)+1 bits.
  - full = (count == DEPTH); empty = (count == 0).
  - Pointers wrap modulo DEPTH.
- No X propagation: imem_instr is sampled only on push edges.

Test Plan:
- Memory model: 0x00=FFC4A303, 0x04=0064A423, 0x08=0062E233, 0x0C=FE420AE3.
- Reset release with instr_ready=1:
  - Expect instr_valid=1 after the 1st edge, with instr_pc=0x00, instr=FFC4A303.
  - Then 0x04/0064A423, 0x08/0062E233, 0x0C/FE420AE3 on consecutive cycles.
- Backpressure:
  - Hold instr_ready=0 from reset. After 2 edges, count=2 (full) and imem_pc=0x08 stays stable.
  - Head remains 0x00/FFC4A303.
  - Raise instr_ready: entries 0x00, 0x04, 0x08 delivered in order with no loss or duplication.
- Redirect while full:
  - redirect_valid=1, redirect_pc=0x0E. Expect FIFO empty and instr_valid=0 the next cycle.
  - pc=0x0C, so the next delivered entry is 0x0C/FE420AE3.
- Redirect with simultaneous deq: the head is consumed once, the remaining entry is dropped, and there is no duplicate delivery.
- Wrap-around: set RESET_PC=16'hFFF8 and stream. Expect instr_pc sequence FFF8, FFFC, 0000, 0004.
- Async reset mid-stream: assert rst_n=0 between edges. Expect instr_valid=0 and imem_pc=RESET_PC immediately, without waiting for clk.
